// File: rtl/alu_seq_pipe.sv
// N-bit 8-opcode ALU with valid/ready handshakes, accumulator and registered result/flags.
// Define ALU_MUL_EN to build the sequential shift-add multiplier for opcode 110.
module alu_seq_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_PSB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
`else
    typedef enum logic [0:0] {ST_IDLE = 1'b0} state_t;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             overflow;
        logic             err;
    } result_t;

    // Single-cycle opcodes; MUL falls through to the reserved encoding here because the
    // multiplier (when built) produces its result through its own path.
    function automatic result_t alu_eval(input logic [2:0] f_op,
                                         input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
        result_t      r;
        logic [WIDTH:0] wide;
        r    = '0;
        wide = '0;
        case (f_op)
            OP_ADD: begin
                wide       = {1'b0, x} + {1'b0, y};
                r.res      = wide[WIDTH-1:0];
                r.carry    = wide[WIDTH];
                r.overflow = (x[WIDTH-1] == y[WIDTH-1]) && (wide[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                wide       = {1'b0, x} - {1'b0, y};
                r.res      = wide[WIDTH-1:0];
                r.carry    = wide[WIDTH];
                r.overflow = (x[WIDTH-1] != y[WIDTH-1]) && (wide[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:         r.res = x & y;
            OP_OR:          r.res = x | y;
            OP_XOR:         r.res = x ^ y;
            OP_PSB:         r.res = y;
            OP_MUL, OP_RSV: r.err = 1'b1;
            default:        r.err = 1'b1;
        endcase
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] res_r;
    logic             out_valid_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             err_r;

    logic [WIDTH-1:0] opa_s;
    result_t          eval_s;
    result_t          load_val_s;
    logic             accept_s;
    logic             load_s;
    logic             is_mul_s;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   cnt_r;
    result_t            mul_val_s;

    assign is_mul_s = (op == OP_MUL);

    // Final product formatted as a result; overflow means the high half is populated.
    always_comb begin
        mul_val_s          = '0;
        mul_val_s.res      = prod_r[WIDTH-1:0];
        mul_val_s.overflow = |prod_r[2*WIDTH-1:WIDTH];
    end
`else
    assign is_mul_s = 1'b0;
`endif

    assign in_ready  = rst_n && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign eval_s    = alu_eval(op, opa_s, b);
    assign out_valid = out_valid_r;
    assign res       = res_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;
    assign err       = err_r;

    // Operand A source select.
    always_comb begin
        if (use_acc) begin
            opa_s = acc_r;
        end else begin
            opa_s = a;
        end
    end

    // Decide whether the result register loads this cycle and from which path.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = eval_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !is_mul_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (cnt_r == CNT_LAST) begin
                    load_s     = 1'b1;
                    load_val_s = mul_val_s;
                end else begin
                    load_s     = 1'b0;
                    load_val_s = eval_s;
                end
            end
`endif
            default: load_s = 1'b0;
        endcase
    end

    // Control FSM, multiplier datapath and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            res_r       <= '0;
            out_valid_r <= 1'b0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_r     <= '0;
            prod_r      <= '0;
            mplier_r    <= '0;
            cnt_r       <= '0;
`endif
        end else begin
            // A fresh load wins over consumption so back-to-back ops keep out_valid high.
            if (load_s) begin
                res_r       <= load_val_s.res;
                carry_r     <= load_val_s.carry;
                overflow_r  <= load_val_s.overflow;
                err_r       <= load_val_s.err;
                zero_r      <= (load_val_s.res == '0);
                acc_r       <= load_val_s.res;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
`ifdef ALU_MUL_EN
                    if (accept_s && is_mul_s) begin
                        mcand_r  <= {{WIDTH{1'b0}}, opa_s};
                        mplier_r <= b;
                        prod_r   <= '0;
                        cnt_r    <= '0;
                        state_r  <= ST_MUL;
                    end
`else
                    state_r <= ST_IDLE;
`endif
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        if (mplier_r[0]) begin
                            prod_r <= prod_r + mcand_r;
                        end
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Scoreboard bench for alu_seq_pipe (WIDTH=4): driver pushes model results, monitor compares.
module tb_alu_seq_pipe;
    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         use_acc = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, carry, overflow, zero, err;
    logic [W-1:0] res;

    typedef struct {
        int res;
        int carry;
        int ov;
        int zero;
        int err;
        int cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   acc_m = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fresh = 1'b1;
    bit   rnd_rdy = 1'b0;

    alu_seq_pipe #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .use_acc(use_acc),
        .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .carry(carry), .overflow(overflow), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over the opcode rules.
    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int sx, sy, s;
        e = '{default: 0};
        e.lat = 1;
        sx = (x >= H) ? x - M : x;
        sy = (y >= H) ? y - M : y;
        case (o)
            0: begin
                s = x + y; e.res = s % M; e.carry = int'(s >= M);
                e.ov = int'((sx + sy >= H) || (sx + sy < -H));
            end
            1: begin
                s = x - y; e.res = (s + M) % M; e.carry = int'(x < y);
                e.ov = int'((sx - sy >= H) || (sx - sy < -H));
            end
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: e.res = y;
`ifdef ALU_MUL_EN
            6: begin s = x * y; e.res = s % M; e.ov = int'(s >= M); e.lat = W + 1; end
`endif
            default: e.err = 1;
        endcase
        e.zero = int'(e.res == 0);
        return e;
    endfunction

    // Called between a rising edge and the next falling edge.
    task automatic issue(input int o, input int x, input int y, input bit ua);
        int   n;
        exp_t e;
        op = 3'(o); a = W'(x); b = W'(y); use_acc = ua; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = ($urandom % 4) != 0;
        end
        e = model(o, ua ? acc_m : (x % M), y % M);
        e.cyc = cyc;
        sb.push_back(e);
        acc_m = e.res;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd_rdy) out_ready = ($urandom % 4) != 0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
        end
    endtask

    // Monitor: a new result is popped when it first appears; held values are re-checked.
    always @(negedge clk) begin
        if (!rst_n) begin
            fresh = 1'b1;
        end else if (out_valid) begin
            if (fresh) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: out_valid=1 res=%0d with empty scoreboard", res);
                    cur = '{default: 0};
                end else begin
                    cur = sb.pop_front();
                    chk("latency", cyc - cur.cyc, cur.lat);
                end
                fresh = 1'b0;
            end
            chk("res", int'(res), cur.res);
            chk("carry", int'(carry), cur.carry);
            chk("overflow", int'(overflow), cur.ov);
            chk("zero", int'(zero), cur.zero);
            chk("err", int'(err), cur.err);
            if (out_ready) fresh = 1'b1;
        end
    end

    initial begin
        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_flags", int'({carry, overflow, zero, err}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("post_rst_in_ready", int'(in_ready), 1);

        issue(0, 7, 1, 1'b0);
        issue(1, 0, 1, 1'b0);
        issue(1, 5, 5, 1'b0);
        issue(0, 2, 3, 1'b0);
        issue(0, 0, 4, 1'b1);
        issue(1, 0, 9, 1'b1);
        issue(7, 3, 3, 1'b0);
        drain();

        // Backpressure: result held, in_ready low; then consume and accept on the same edge.
        out_ready = 1'b0;
        issue(0, 3, 4, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #2;
        chk("bp_release_in_ready", int'(in_ready), 1);
        issue(2, 12, 10, 1'b0);

        issue(6, 5, 3, 1'b0);
        issue(6, 6, 3, 1'b0);
        drain();

        // Reset in the middle of an operation: nothing emitted, accumulator cleared.
`ifdef ALU_MUL_EN
        issue(6, 7, 7, 1'b0);
`else
        out_ready = 1'b0;
        issue(0, 9, 9, 1'b0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        sb.delete();
        acc_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("rel_in_ready", int'(in_ready), 1);
        chk("rel_out_valid", int'(out_valid), 0);
        issue(0, 0, 3, 1'b1);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom % 8), int'($urandom % M), int'($urandom % M), 1'($urandom % 2));
        end
        rnd_rdy = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
